// File: rtl/router_src_ingress_if.sv
// Source-side byte bus plus destination FIFO write port for the router ingress engine.
// The slave modport is the ingress engine; the master modport is the source/FIFO side.
interface router_src_ingress_if #(
  parameter int DW       = 8,
  parameter int NUM_DEST = 3,
  parameter int ADDR_W   = 2
);
  logic [DW-1:0]       d_in;
  logic                pkt_vld;
  logic [NUM_DEST-1:0] fifo_full;
  logic                busy;
  logic                error;
  logic [NUM_DEST-1:0] wr_en;
  logic [DW-1:0]       wr_data;
  logic [ADDR_W-1:0]   dest;
  logic                pkt_done;
  logic                pkt_abort;

  modport slave (
    input  d_in, pkt_vld, fifo_full,
    output busy, error, wr_en, wr_data, dest, pkt_done, pkt_abort
  );

  modport master (
    output d_in, pkt_vld, fifo_full,
    input  busy, error, wr_en, wr_data, dest, pkt_done, pkt_abort
  );
endinterface

// File: rtl/router_src_ingress.sv
// Router source ingress: decodes header, steers bytes to the addressed FIFO,
// checks XOR parity, drops illegal addresses and aborts stalled packets on timeout.
module router_src_ingress #(
  parameter int DW       = 8,
  parameter int NUM_DEST = 3,
  parameter int ADDR_W   = 2,
  parameter int TIMEOUT  = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  router_src_ingress_if.slave  bus
);
  localparam int LW = DW - ADDR_W;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, PAYLOAD, PARITY, DROP, CHECK} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [LW-1:0]       rem_q, rem_d;
  logic [DW-1:0]       par_q, par_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic                mis_q, mis_d;
  logic                bad_q, bad_d;
  logic                tmo_q, tmo_d;
  logic                error_q, error_d;

  logic [ADDR_W-1:0]   hdr_addr;
  logic [LW-1:0]       hdr_len;
  logic [NUM_DEST-1:0] hdr_sel, dest_sel, wr_sel;
  logic                busy_c, accept, wr_ok;

  assign hdr_addr = bus.d_in[ADDR_W-1:0];
  assign hdr_len  = bus.d_in[DW-1:ADDR_W];

  // Address decode; an illegal address simply matches no destination.
  always_comb begin
    hdr_sel  = '0;
    dest_sel = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      hdr_sel[i]  = (hdr_addr == ADDR_W'(i));
      dest_sel[i] = (dest_q == ADDR_W'(i));
    end
  end

  always_comb begin
    busy_c = 1'b0;
    wr_sel = dest_sel;
    case (state_q)
      IDLE: begin
        busy_c = bus.pkt_vld && (|(bus.fifo_full & hdr_sel));
        wr_sel = hdr_sel;
      end
      PAYLOAD, PARITY: busy_c = |(bus.fifo_full & dest_sel);
      CHECK:           busy_c = 1'b1;
      default:         busy_c = 1'b0;
    endcase
  end

  // Holding reset blocks both the handshake and any FIFO write.
  assign accept = resetn && bus.pkt_vld && !busy_c;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    rem_d   = rem_q;
    par_d   = par_q;
    tcnt_d  = tcnt_q;
    mis_d   = mis_q;
    bad_d   = bad_q;
    tmo_d   = tmo_q;
    error_d = error_q;
    wr_ok   = 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (accept) begin
          dest_d = hdr_addr;
          rem_d  = hdr_len;
          par_d  = bus.d_in;
          if (|hdr_sel) begin
            wr_ok   = 1'b1;
            state_d = (hdr_len != '0) ? PAYLOAD : PARITY;
          end else begin
            bad_d   = 1'b1;
            state_d = DROP;
          end
        end
      end
      PAYLOAD: if (accept) begin
        wr_ok = 1'b1;
        par_d = par_q ^ bus.d_in;
        rem_d = rem_q - LW'(1);
        if (rem_q == LW'(1)) state_d = PARITY;
      end
      PARITY: if (accept) begin
        wr_ok   = 1'b1;
        mis_d   = (bus.d_in != par_q);
        state_d = CHECK;
      end
      DROP: if (accept) begin
        if (rem_q != '0) begin
          par_d = par_q ^ bus.d_in;
          rem_d = rem_q - LW'(1);
        end else begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        error_d = mis_q | bad_q | tmo_q;
        mis_d   = 1'b0;
        bad_d   = 1'b0;
        tmo_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Only idle source cycles count toward the stall timeout.
    if (state_q == PAYLOAD || state_q == PARITY || state_q == DROP) begin
      if (bus.pkt_vld) begin
        tcnt_d = '0;
      end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
        tcnt_d  = '0;
        tmo_d   = 1'b1;
        state_d = CHECK;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      dest_q  <= '0;
      rem_q   <= '0;
      par_q   <= '0;
      tcnt_q  <= '0;
      mis_q   <= 1'b0;
      bad_q   <= 1'b0;
      tmo_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      rem_q   <= rem_d;
      par_q   <= par_d;
      tcnt_q  <= tcnt_d;
      mis_q   <= mis_d;
      bad_q   <= bad_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
    end
  end

  assign bus.busy      = resetn && busy_c;
  assign bus.wr_en     = wr_ok ? wr_sel : '0;
  assign bus.wr_data   = bus.d_in;
  assign bus.dest      = dest_q;
  assign bus.error     = error_q;
  assign bus.pkt_done  = (state_q == CHECK) && !tmo_q;
  assign bus.pkt_abort = (state_q == CHECK) && tmo_q;
endmodule

// File: tb/tb_router_src_ingress.sv
// Directed bench for router_src_ingress: normal, bad parity, stall, illegal address,
// async reset mid-packet and timeout abort, with hand-computed expectations.
module tb_router_src_ingress;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [7:0] pkt [8];

  always #5 clk = ~clk;

  router_src_ingress_if #(.DW(8), .NUM_DEST(3), .ADDR_W(2)) bus ();

  router_src_ingress #(.DW(8), .NUM_DEST(3), .ADDR_W(2), .TIMEOUT(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and settle before sampling.
  task automatic drive(input logic [7:0] d, input logic v, input logic [2:0] f);
    @(negedge clk);
    bus.d_in      = d;
    bus.pkt_vld   = v;
    bus.fifo_full = f;
    #1;
  endtask

  // Sends pkt[0..n-1] back-to-back, then checks CHECK cycle and the resulting status.
  task automatic send_pkt(input string tag, input int n, input logic [2:0] exp_we,
                          input logic exp_err, input logic [1:0] exp_dest);
    for (int i = 0; i < n; i++) begin
      drive(pkt[i], 1'b1, 3'b000);
      check({tag, ".busy"}, bus.busy, 0);
      check({tag, ".we"}, bus.wr_en, exp_we);
      check({tag, ".wd"}, bus.wr_data, pkt[i]);
    end
    drive(8'h00, 1'b0, 3'b000);
    check({tag, ".chk_busy"}, bus.busy, 1);
    check({tag, ".done"}, bus.pkt_done, 1);
    check({tag, ".abort"}, bus.pkt_abort, 0);
    drive(8'h00, 1'b0, 3'b000);
    check({tag, ".err"}, bus.error, exp_err);
    check({tag, ".dest"}, bus.dest, exp_dest);
    check({tag, ".done_low"}, bus.pkt_done, 0);
  endtask

  initial begin
    bus.d_in = '0;
    bus.pkt_vld = 1'b0;
    bus.fifo_full = '0;
    #1;
    check("rst.busy", bus.busy, 0);
    check("rst.err", bus.error, 0);
    check("rst.we", bus.wr_en, 0);
    check("rst.dest", bus.dest, 0);
    check("rst.done", bus.pkt_done, 0);
    check("rst.abort", bus.pkt_abort, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Good packet to FIFO 1
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00, 8'h00};
    send_pkt("good", 5, 3'b010, 1'b0, 2'd1);

    // Bad parity, then a good packet clears error
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C, 8'h00, 8'h00, 8'h00};
    send_pkt("badpar", 5, 3'b010, 1'b1, 2'd1);
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00, 8'h00};
    send_pkt("clear", 5, 3'b010, 1'b0, 2'd1);

    // FIFO 1 full for 3 cycles while 0x22 is presented
    drive(8'h0D, 1'b1, 3'b000);
    check("stall.hdr_we", bus.wr_en, 3'b010);
    drive(8'h11, 1'b1, 3'b000);
    check("stall.p0_we", bus.wr_en, 3'b010);
    for (int i = 0; i < 3; i++) begin
      drive(8'h22, 1'b1, 3'b010);
      check("stall.busy", bus.busy, 1);
      check("stall.we", bus.wr_en, 0);
    end
    drive(8'h22, 1'b1, 3'b000);
    check("stall.rel_busy", bus.busy, 0);
    check("stall.rel_we", bus.wr_en, 3'b010);
    check("stall.rel_wd", bus.wr_data, 8'h22);
    drive(8'h33, 1'b1, 3'b000);
    check("stall.p2_we", bus.wr_en, 3'b010);
    drive(8'h0D, 1'b1, 3'b000);
    check("stall.par_we", bus.wr_en, 3'b010);
    drive(8'h00, 1'b0, 3'b000);
    check("stall.done", bus.pkt_done, 1);
    drive(8'h00, 1'b0, 3'b000);
    check("stall.err", bus.error, 0);

    // Illegal address 3 is dropped
    pkt = '{8'h07, 8'hAA, 8'hAD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt("drop", 3, 3'b000, 1'b1, 2'd3);

    // Asynchronous reset in the middle of a payload
    drive(8'h0D, 1'b1, 3'b000);
    check("arst.hdr_we", bus.wr_en, 3'b010);
    drive(8'h11, 1'b1, 3'b000);
    check("arst.p0_we", bus.wr_en, 3'b010);
    @(negedge clk);
    bus.d_in = 8'h22;
    #2;
    resetn = 1'b0;
    #1;
    check("arst.busy", bus.busy, 0);
    check("arst.we", bus.wr_en, 0);
    check("arst.err", bus.error, 0);
    check("arst.dest", bus.dest, 0);
    check("arst.done", bus.pkt_done, 0);
    @(negedge clk);
    bus.pkt_vld = 1'b0;
    resetn = 1'b1;
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00, 8'h00};
    send_pkt("after_rst", 5, 3'b010, 1'b0, 2'd1);

    // Timeout: header to FIFO 2, then the source goes silent
    drive(8'h0E, 1'b1, 3'b000);
    check("tmo.hdr_we", bus.wr_en, 3'b100);
    for (int i = 0; i < 16; i++) begin
      drive(8'h00, 1'b0, 3'b000);
      check("tmo.we", bus.wr_en, 0);
      check("tmo.abort_early", bus.pkt_abort, 0);
    end
    drive(8'h00, 1'b0, 3'b000);
    check("tmo.abort", bus.pkt_abort, 1);
    check("tmo.done", bus.pkt_done, 0);
    check("tmo.busy", bus.busy, 1);
    drive(8'h00, 1'b0, 3'b000);
    check("tmo.err", bus.error, 1);
    check("tmo.abort_low", bus.pkt_abort, 0);
    check("tmo.dest", bus.dest, 2);

    // Zero-length packet to FIFO 0
    pkt = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt("zero_len", 2, 3'b001, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/router_src_ingress.md
Name: router_src_ingress

Overview:
Parametrised source-side packet ingress engine for the router, generalising the fixed 8-bit, 3-port source interface. It accepts one byte per clock from the packet source using the pkt_vld/busy handshake, decodes the header's destination and length, and steers every packet byte to the selected destination FIFO's write port. It accumulates and checks XOR parity, drops packets with an illegal address, and aborts stalled packets on timeout. It sits between the source agent's bus and the per-destination FIFOs.

Parameters:
DW, 8, data/byte width; header = {len[DW-1:ADDR_W], addr[ADDR_W-1:0]}
NUM_DEST, 3, number of destination FIFOs; must satisfy NUM_DEST <= 2**ADDR_W
ADDR_W, 2, width of header address field
TIMEOUT, 16, consecutive mid-packet pkt_vld-low cycles that trigger an abort; must be >= 2

Ports:
clk  input  1  single clock; all state updates on posedge
resetn  input  1  asynchronous, active-low reset
d_in  input  DW  packet byte from source
pkt_vld  input  1  source presents a valid byte on d_in
fifo_full  input  NUM_DEST  per-destination FIFO full flags
busy  output  1  stall request to source; source holds d_in while busy=1
error  output  1  registered status of last completed packet (parity mismatch, bad address, or abort)
wr_en  output  NUM_DEST  one-hot FIFO write strobe
wr_data  output  DW  FIFO write data (= d_in)
dest  output  ADDR_W  latched address of the current/last packet
pkt_done  output  1  one-cycle pulse, packet completed normally or dropped
pkt_abort  output  1  one-cycle pulse, packet aborted by timeout

Behaviour:
- Reset (async, resetn=0): state=IDLE; busy, error, pkt_done, pkt_abort, dest, wr_en all 0; counters and parity accumulator cleared. Reset mid-packet discards the packet; no further writes occur.
- Transfer: a byte is accepted at posedge when pkt_vld=1 and busy=0. wr_data=d_in combinationally. The accepted byte's wr_en[dest] is asserted in the same cycle (zero latency) for a legal address.
- States: IDLE, PAYLOAD, PARITY, DROP, CHECK.
- IDLE:
  - busy = pkt_vld && (addr field < NUM_DEST) && fifo_full[addr field].
  - On accept, latch dest, remaining = len, and par = d_in.
  - Legal addr: write the header; go to PAYLOAD if len>0, else PARITY.
  - Illegal addr (>= NUM_DEST): no write; go to DROP with bad flag set.
- PAYLOAD:
  - busy = fifo_full[dest].
  - On accept: write; par ^= d_in; remaining--.
  - When the accepted byte makes remaining 0, go to PARITY.
- PARITY:
  - busy = fifo_full[dest].
  - On accept: write the parity byte; mismatch flag = (d_in != par); go to CHECK.
- DROP:
  - busy = 0; no writes; bytes are counted through the same length/parity sequence.
  - After the parity byte is accepted, go to CHECK.
- CHECK (exactly 1 cycle):
  - busy = 1.
  - error <= mismatch | bad | timeout flag.
  - pkt_done=1 unless aborted, in which case pkt_abort=1.
  - Clear flags and return to IDLE.
- error holds its value until the next CHECK.
- Timeout: in PAYLOAD, PARITY, or DROP, a counter increments each cycle pkt_vld=0 and clears whenever pkt_vld=1. Cycles with pkt_vld=1 and busy=1 do not count. On the TIMEOUT-th consecutive low cycle, set the timeout flag and go to CHECK. Bytes already written remain in the FIFO.
- FIFO full asserted mid-packet: busy rises combinationally, no write occurs, and state/counters are held. Resume when full deasserts.
- pkt_vld=1 during CHECK: not accepted (busy=1); taken as a new header in IDLE on the next cycle.
- Max length: 2**(DW-ADDR_W)-1 payload bytes (63 at default). Total FIFO writes per legal packet = len+2.

Test Plan:
- Header 0x0D (addr1, len3), payload 0x11,0x22,0x33, parity 0x0D, back-to-back -> wr_en[1] high 5 consecutive cycles with data 0x0D,0x11,0x22,0x33,0x0D; CHECK next cycle with pkt_done=1, error=0, dest=1.
- Same packet with parity 0x0C -> same 5 writes; error=1 after CHECK; a following good packet clears error to 0.
- Same packet with fifo_full[1]=1 for 3 cycles while 0x22 presented -> busy=1 for those 3 cycles, no wr_en, 0x22 written once after release; error=0.
- Header 0x07 (addr3, illegal), payload 0xAA, parity 0xAD -> busy=0 throughout, wr_en never asserted, pkt_done=1, error=1.
- Header 0x0E (addr2, len3) then pkt_vld=0 for 16 cycles -> only header written to FIFO 2, pkt_abort=1, error=1, state IDLE; a subsequent header 0x00 with parity 0x00 -> 2 writes to FIFO 0, error=0.
- resetn pulsed low asynchronously mid-PAYLOAD -> all outputs 0 immediately, no further writes; next packet processed normally.
